if_id_stage: RTL and testbench

//  Parametrised IF/ID pipeline stage register with valid/ready handshake, stall and flush.

---
 rtl/if_id_stage.sv | 160 ++++++++++++++++
 tb/tb_if_id_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage register with valid/ready handshake, hazard stall, flush and a
// saturating bubble counter. Define SKID_BUF_EN to build the 2-entry (main + skid) variant.
module if_id_stage #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc4_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc4_out,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic accept;
  logic drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready & enable;

  // A bubble is a cycle in which decode could have consumed but nothing was there.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (reset) begin
      bubble_cnt <= '0;
    end else if (enable && out_ready && !out_valid && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

`ifdef SKID_BUF_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               ld_main_in;
  logic               ld_main_skid;
  logic               ld_skid;
  logic               empty_main;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc4;

  // Readiness depends only on registered state, never on out_ready.
  assign in_ready  = ~reset & enable & ~clear & (state != FULL);
  assign out_valid = (state != EMPTY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    empty_main   = 1'b0;
    if (clear) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt  = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            state_nxt = FULL;
            ld_skid   = 1'b1;
          end else if (accept && drain) begin
            ld_main_in = 1'b1;
          end else if (drain) begin
            state_nxt  = EMPTY;
            empty_main = 1'b1;
          end
        end
        FULL: begin
          if (drain) begin
            state_nxt    = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_out  <= NOP_INSTR;
      pc4_out    <= '0;
      // NOTE: the skid slot is reset too, so nothing undefined can ever be promoted to the outputs.
      skid_instr <= NOP_INSTR;
      skid_pc4   <= '0;
    end else if (clear) begin
      instr_out <= NOP_INSTR;
      pc4_out   <= '0;
    end else begin
      if (ld_main_in) begin
        instr_out <= instr_in;
        pc4_out   <= pc4_in;
      end else if (ld_main_skid) begin
        instr_out <= skid_instr;
        pc4_out   <= skid_pc4;
      end else if (empty_main) begin
        instr_out <= NOP_INSTR;
      end
      if (ld_skid) begin
        skid_instr <= instr_in;
        skid_pc4   <= pc4_in;
      end
    end
  end

`else

  // Single slot: a full slot can take a new instruction only when it is consumed the same cycle.
  assign in_ready = ~reset & enable & ~clear & (~out_valid | out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      instr_out <= NOP_INSTR;
      pc4_out   <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      instr_out <= NOP_INSTR;
      pc4_out   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      instr_out <= instr_in;
      pc4_out   <= pc4_in;
    end else if (drain) begin
      out_valid <= 1'b0;
      instr_out <= NOP_INSTR;
    end
  end

`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: accepted instructions are queued, and a monitor checks
// every drained instruction in order, alongside directed checks of reset, stall, flush and counters.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset, clear, enable, in_valid, out_ready;
  logic [31:0] instr_in, pc4_in;
  logic        in_ready, out_valid;
  logic [31:0] instr_out, pc4_out;
  logic [15:0] bubble_cnt;
  logic        in_ready4, out_valid4;
  logic [31:0] instr_out4, pc4_out4;
  logic [3:0]  bubble_cnt4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } item_t;

  item_t exp_q[$];
  item_t mon_e;
  item_t t5_items[3];
  int    checks   = 0;
  int    failures = 0;
  int    pops     = 0;
  int    pops_t5;
  int    idx;
  int    budget;
  logic  acc;

  if_id_stage dut (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in), .pc4_in(pc4_in),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .pc4_out(pc4_out), .bubble_cnt(bubble_cnt)
  );

  if_id_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready4), .instr_in(instr_in), .pc4_in(pc4_in),
    .out_valid(out_valid4), .out_ready(out_ready), .instr_out(instr_out4),
    .pc4_out(pc4_out4), .bubble_cnt(bubble_cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] i, input logic [31:0] p);
    in_valid = v;
    instr_in = i;
    pc4_in   = p;
  endtask

  // Monitor: pops on every drain, pushes on every accept; reset and flush discard in-flight work.
  always @(negedge clk) begin
    if (reset || clear) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && enable) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got 0x%0h expected none", instr_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("drain_instr", instr_out, mon_e.instr);
          check("drain_pc4", pc4_out, mon_e.pc4);
          pops++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back({instr_in, pc4_in});
      if (!out_valid) check("idle_nop", instr_out, 32'h0);
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; enable = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_instr", instr_out, 0);
    check("rst_pc4", pc4_out, 0);
    check("rst_bubble", bubble_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;

    // Streaming: one instruction per cycle, visible one cycle after it is offered.
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 32'h2008_0000 + 32'(i), 32'(4 * i));
      cyc();
      check("t2_valid", out_valid, 1);
      check("t2_instr", instr_out, 32'h2008_0000 + 32'(i));
      check("t2_pc4", pc4_out, 32'(4 * i));
    end
    in_valid = 1'b0;
    cyc();
    check("t2_drained", out_valid, 0);
    check("t2_bubble", bubble_cnt, 1);

    // Stall: enable low freezes the slot and the counter.
    set_in(1'b1, 32'h8C09_0004, 32'h100);
    cyc();
    check("t3_loaded", instr_out, 32'h8C09_0004);
    check("t3_bubble0", bubble_cnt, 2);
    enable = 1'b0;
    set_in(1'b1, 32'hDEAD_BEEF, 32'h200);
    #1;
    check("t3_in_ready", in_ready, 0);
    repeat (3) begin
      cyc();
      check("t3_hold_instr", instr_out, 32'h8C09_0004);
      check("t3_hold_pc4", pc4_out, 32'h100);
      check("t3_hold_valid", out_valid, 1);
      check("t3_in_ready_hold", in_ready, 0);
      check("t3_bubble", bubble_cnt, 2);
    end

    // Flush: clear wins over the offered instruction and the held one.
    enable = 1'b1; out_ready = 1'b0; clear = 1'b1;
    set_in(1'b1, 32'h1000_FFFF, 32'h300);
    #1;
    check("t4_in_ready", in_ready, 0);
    cyc();
    clear = 1'b0; in_valid = 1'b0;
    check("t4_valid", out_valid, 0);
    check("t4_instr", instr_out, 0);
    check("t4_pc4", pc4_out, 0);
    check("t4_bubble", bubble_cnt, 2);
    out_ready = 1'b1;
    cyc();
    check("t4_bubble_after", bubble_cnt, 3);

    // Backpressure: A, B, C under out_ready=0, then released.
    t5_items[0] = {32'hAAAA_0001, 32'h400};
    t5_items[1] = {32'hBBBB_0002, 32'h404};
    t5_items[2] = {32'hCCCC_0003, 32'h408};
    out_ready = 1'b0;
    set_in(1'b1, t5_items[0].instr, t5_items[0].pc4);
    #1;
    check("t5_in_ready_a", in_ready, 1);
    cyc();
    check("t5_a_loaded", instr_out, t5_items[0].instr);
    set_in(1'b1, t5_items[1].instr, t5_items[1].pc4);
    #1;
`ifdef SKID_BUF_EN
    check("t5_in_ready_b", in_ready, 1);
    cyc();
    set_in(1'b1, t5_items[2].instr, t5_items[2].pc4);
    idx = 2;
`else
    check("t5_in_ready_b", in_ready, 0);
    cyc();
    idx = 1;
`endif
    #1;
    check("t5_in_ready_full", in_ready, 0);
    check("t5_a_held", instr_out, t5_items[0].instr);
    cyc();
    check("t5_a_held2", instr_out, t5_items[0].instr);
    out_ready = 1'b1;
    pops_t5 = pops;
    budget = 0;
    while (budget < 20 && (idx < 3 || out_valid)) begin
      if (idx < 3) set_in(1'b1, t5_items[idx].instr, t5_items[idx].pc4);
      else         in_valid = 1'b0;
      @(negedge clk);
      acc = in_valid & in_ready;
      cyc();
      if (acc) idx++;
      budget++;
    end
    in_valid = 1'b0;
    check("t5_all_sent", 32'(idx), 3);
    check("t5_pops", 32'(pops - pops_t5), 3);
    check("t5_queue_empty", 32'(exp_q.size()), 0);

    // Reset mid-stream: outputs clear immediately, before any clock edge.
    out_ready = 1'b0;
    set_in(1'b1, 32'h1234_5678, 32'h500);
    cyc();
    check("t1_loaded", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t1_valid", out_valid, 0);
    check("t1_instr", instr_out, 0);
    check("t1_pc4", pc4_out, 0);
    check("t1_bubble", bubble_cnt, 0);
    check("t1_in_ready", in_ready, 0);
    in_valid = 1'b0;
    cyc();
    reset = 1'b0;

    // Saturation: the 4-bit counter stops at 15 while the 16-bit one keeps counting.
    enable = 1'b1; out_ready = 1'b1;
    repeat (5) cyc();
    check("t6_cnt16_5", bubble_cnt, 5);
    check("t6_cnt4_5", bubble_cnt4, 5);
    repeat (15) cyc();
    check("t6_cnt16_20", bubble_cnt, 20);
    check("t6_cnt4_sat", bubble_cnt4, 15);
    check("t6_d4_valid", out_valid4, 0);
    check("t6_d4_instr", instr_out4, 0);
    check("t6_d4_pc4", pc4_out4, 0);
    check("t6_d4_in_ready", in_ready4, 1);
    reset = 1'b1;
    #1;
    check("t6_cnt4_reset", bubble_cnt4, 0);
    check("t6_cnt16_reset", bubble_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
